// File: rtl/uvmt_cv32e40x_obi_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uvmt_cv32e40x_obi_resp_pkg
// Purpose  : Shared types and constants for the OBI memory responder:
//            grant FSM state encoding, response FIFO entry layout and the
//            LFSR seed/tap constants used by the optional stall randomiser.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uvmt_cv32e40x_obi_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_GRANT = 2'd2
    } obi_gnt_state_e;

    // One pending response: data, error flag and remaining cycles to rvalid.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  age;
    } obi_resp_entry_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10.
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

endpackage
`default_nettype wire

// File: rtl/uvmt_cv32e40x_obi_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uvmt_cv32e40x_obi_resp_fifo
// Purpose  : In-order FIFO of pending OBI responses. Only the head entry
//            ages: its age counts down by one per cycle until it reaches zero
//            and the entry is popped.
// Ports    : clk_i, rst_ni      - clock, async active-low reset
//            push_i, entry_i    - write a new entry at the tail
//            pop_i              - remove the head entry
//            head_o             - current head entry
//            full_o, empty_o    - occupancy flags
//            count_o            - occupancy (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module uvmt_cv32e40x_obi_resp_fifo
    import uvmt_cv32e40x_obi_resp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  obi_resp_entry_t          entry_i,
    input  logic                     pop_i,
    output obi_resp_entry_t          head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int                c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_depth = (c_aw + 1)'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty differ.
    logic [c_aw:0]   r_wptr_q, w_wptr_d;
    logic [c_aw:0]   r_rptr_q, w_rptr_d;
    obi_resp_entry_t r_mem_q [DEPTH];
    logic [c_aw:0]   w_count;
    logic            w_push;
    logic            w_pop;
    logic            w_age_dec;

    assign w_count = r_wptr_q - r_rptr_q;
    assign full_o  = (w_count == c_depth);
    assign empty_o = (w_count == '0);
    assign count_o = w_count;
    assign head_o  = r_mem_q[r_rptr_q[c_aw-1:0]];

    // A push into a full FIFO is legal only when the head leaves this cycle.
    assign w_pop     = pop_i && !empty_o;
    assign w_push    = push_i && (!full_o || w_pop);
    assign w_age_dec = !empty_o && !w_pop && (head_o.age != 4'd0);

    always_comb begin
        w_wptr_d = r_wptr_q;
        w_rptr_d = r_rptr_q;
        if (w_push) w_wptr_d = r_wptr_q + 1'b1;
        if (w_pop)  w_rptr_d = r_rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr_q <= '0;
            r_rptr_q <= '0;
        end else begin
            r_wptr_q <= w_wptr_d;
            r_rptr_q <= w_rptr_d;
        end
    end

    // Head ageing never targets the push slot: when pushing into an empty
    // FIFO there is no head, and a full FIFO only accepts a push on a pop.
    always_ff @(posedge clk_i) begin
        if (w_push)    r_mem_q[r_wptr_q[c_aw-1:0]]     <= entry_i;
        if (w_age_dec) r_mem_q[r_rptr_q[c_aw-1:0]].age <= head_o.age - 4'd1;
    end

endmodule
`default_nettype wire

// File: rtl/uvmt_cv32e40x_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : uvmt_cv32e40x_obi_mem_responder
// Purpose  : OBI data-side slave memory model. Address phase with a
//            programmable grant stall, in-order response phase with a
//            programmable rvalid latency, word-addressed RAM backing store
//            and a bus-error address window.
// Ports    : clk_i, rst_ni            - clock, async active-low reset
//            req_i/gnt_o/addr_i/we_i/be_i/wdata_i - OBI address phase
//            rvalid_o/rdata_o/err_o   - OBI response phase
//            gnt_delay_i              - grant stall in cycles
//            rvalid_delay_i           - extra response latency in cycles
//            outstanding_o            - pending response count
// Options  : UVMT_OBI_RESP_LFSR_STALL_EN - mask both delays with bits of a
//            free-running 16-bit LFSR for reproducible pseudo-random stalls.
// Revision : 1.0 - initial release
// ============================================================================
module uvmt_cv32e40x_obi_mem_responder
    import uvmt_cv32e40x_obi_resp_pkg::*;
#(
    parameter int          RAM_ADDR_WIDTH  = 12,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] ERR_BASE        = 32'hFFFF_0000,
    parameter logic [31:0] ERR_LIMIT       = 32'hFFFF_FFFF
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 req_i,
    output logic                                 gnt_o,
    input  logic [31:0]                          addr_i,
    input  logic                                 we_i,
    input  logic [3:0]                           be_i,
    input  logic [31:0]                          wdata_i,
    output logic                                 rvalid_o,
    output logic [31:0]                          rdata_o,
    output logic                                 err_o,
    input  logic [3:0]                           gnt_delay_i,
    input  logic [3:0]                           rvalid_delay_i,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o
);

    // Window test as an offset compare so an all-ones limit stays meaningful.
    localparam logic [31:0] c_err_span = ERR_LIMIT - ERR_BASE;

    logic [3:0]                  w_gnt_dly;
    logic [3:0]                  w_rv_dly;

    obi_gnt_state_e              r_state_q, w_state_d;
    logic [3:0]                  r_cnt_q, w_cnt_d;
    logic                        w_gnt_ready;
    logic                        w_gnt;
    logic                        w_can_push;

    logic [31:0]                 r_ram_q [2**RAM_ADDR_WIDTH];
    logic [RAM_ADDR_WIDTH-1:0]   w_idx;
    logic                        w_err;
    logic                        w_wr_en;

    obi_resp_entry_t             w_push_entry;
    obi_resp_entry_t             w_head;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_pop;

`ifdef UVMT_OBI_RESP_LFSR_STALL_EN
    logic [15:0] r_lfsr_q, w_lfsr_d;

    assign w_lfsr_d = {r_lfsr_q[14:0], ^(r_lfsr_q & c_lfsr_taps)};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_lfsr_q <= c_lfsr_seed;
        else         r_lfsr_q <= w_lfsr_d;
    end

    assign w_gnt_dly = gnt_delay_i    & r_lfsr_q[3:0];
    assign w_rv_dly  = rvalid_delay_i & r_lfsr_q[7:4];
`else
    assign w_gnt_dly = gnt_delay_i;
    assign w_rv_dly  = rvalid_delay_i;
`endif

    // ---------------------------------------------------------------- grant
    // A slot is available if the FIFO has room or the head leaves this cycle.
    assign w_can_push = !w_full || w_pop;

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_gnt_ready = 1'b0;
        unique case (r_state_q)
            ST_IDLE:  w_gnt_ready = (w_gnt_dly == 4'd0);
            ST_STALL: w_gnt_ready = (r_cnt_q == 4'd0);
            ST_GRANT: w_gnt_ready = 1'b1;
            default:  w_gnt_ready = 1'b0;
        endcase

        w_gnt = req_i && w_can_push && w_gnt_ready;

        if (w_gnt) begin
            // A request still held next cycle restarts from IDLE, which
            // reloads the stall or grants at once for a zero delay.
            w_state_d = ST_IDLE;
        end else begin
            unique case (r_state_q)
                ST_IDLE: begin
                    // Counter holds the remaining stall cycles minus one so
                    // that gnt_o lands exactly gnt_delay cycles after req_i.
                    if (req_i && w_can_push) begin
                        w_state_d = ST_STALL;
                        w_cnt_d   = w_gnt_dly - 4'd1;
                    end
                end
                ST_STALL: begin
                    if (r_cnt_q == 4'd0) w_state_d = ST_GRANT;
                    else                 w_cnt_d   = r_cnt_q - 4'd1;
                end
                ST_GRANT: w_state_d = ST_GRANT;
                default:  w_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= 4'd0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign gnt_o = w_gnt;

    // ------------------------------------------------------------------ RAM
    assign w_idx   = addr_i[RAM_ADDR_WIDTH+1:2];
    assign w_err   = ((addr_i - ERR_BASE) <= c_err_span);
    assign w_wr_en = w_gnt && we_i && !w_err;

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) r_ram_q[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Reads return the pre-write array contents; writes and errors return 0.
    always_comb begin
        w_push_entry.rdata = (we_i || w_err) ? 32'd0 : r_ram_q[w_idx];
        w_push_entry.err   = w_err;
        w_push_entry.age   = w_rv_dly;
    end

    // ------------------------------------------------------------- response
    uvmt_cv32e40x_obi_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_gnt),
        .entry_i (w_push_entry),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (outstanding_o)
    );

    assign w_pop    = !w_empty && (w_head.age == 4'd0);
    assign rvalid_o = w_pop;
    assign rdata_o  = w_pop ? w_head.rdata : 32'd0;
    assign err_o    = w_pop && w_head.err;

endmodule
`default_nettype wire

// File: tb/tb_uvmt_cv32e40x_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uvmt_cv32e40x_obi_mem_responder
// Purpose  : Self-checking bench for the OBI memory responder. Directed
//            scenarios followed by randomised single transactions checked
//            against a word-level memory model and the delay rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uvmt_cv32e40x_obi_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [3:0]  gnt_delay_i;
    logic [3:0]  rvalid_delay_i;
    logic [2:0]  outstanding_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory, indexed by word address bits [13:2].
    logic [31:0] mdl [4096];

    uvmt_cv32e40x_obi_mem_responder dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .addr_i         (addr_i),
        .we_i           (we_i),
        .be_i           (be_i),
        .wdata_i        (wdata_i),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .err_o          (err_o),
        .gnt_delay_i    (gnt_delay_i),
        .rvalid_delay_i (rvalid_delay_i),
        .outstanding_o  (outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One complete transaction on an idle bus: checks grant latency,
    // response latency and response contents against the model.
    task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input int gd, input int rd);
        int          n;
        int          m;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] got_rd;
        logic        got_err;
        logic [11:0] idx;
        idx     = addr[13:2];
        exp_err = (addr >= 32'hFFFF_0000);
        exp_rd  = 32'd0;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                exp_rd = mdl[idx];
            end
        end

        req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
        gnt_delay_i = gd[3:0]; rvalid_delay_i = rd[3:0];
        n = 0;
        while (1) begin
            @(negedge clk_i);
            if (gnt_o || n == 40) break;
            tick();
            n++;
        end
        chk({tag, "_gnt_lat"}, n, gd);
        tick();
        req_i = 1'b0; we_i = 1'b0;

        m = 1; got_rd = 32'hX; got_err = 1'bX;
        while (1) begin
            @(negedge clk_i);
            if (m == 1) chk({tag, "_outst"}, {29'd0, outstanding_o}, 32'd1);
            if (rvalid_o) begin
                got_rd  = rdata_o;
                got_err = err_o;
                break;
            end
            if (m == 40) break;
            tick();
            m++;
        end
        chk({tag, "_rv_lat"}, m, rd + 1);
        chk({tag, "_rdata"}, got_rd, exp_rd);
        chk({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
        tick();
    endtask

    initial begin
        int          grants;
        int          rvs;
        int          k;
        int          sel;
        logic [31:0] a;

        rst_ni = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0;
        wdata_i = '0; gnt_delay_i = '0; rvalid_delay_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_gnt", {31'd0, gnt_o}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_outst", {29'd0, outstanding_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Basic write/read, zero delays.
        do_txn("wr_beef", 1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 0, 0);
        do_txn("rd_beef", 1'b0, 32'h0000_0100, 4'hF, 32'h0,        0, 0);

        // Partial byte-enable write.
        do_txn("wr_base", 1'b1, 32'h0000_0104, 4'hF,    32'h1122_3344, 0, 0);
        do_txn("wr_part", 1'b1, 32'h0000_0104, 4'b0010, 32'h0000_5500, 1, 1);
        do_txn("rd_part", 1'b0, 32'h0000_0104, 4'hF,    32'h0,         0, 0);

        // Programmed stalls.
        do_txn("rd_dly", 1'b0, 32'h0000_0100, 4'hF, 32'h0, 3, 2);

        // Error window: read and write; aliased RAM word untouched.
        do_txn("err_rd",  1'b0, 32'hFFFF_0010, 4'hF, 32'h0,         0, 0);
        do_txn("err_wr",  1'b1, 32'hFFFF_0100, 4'hF, 32'h1234_5678, 2, 1);
        do_txn("err_chk", 1'b0, 32'h0000_0100, 4'hF, 32'h0,         0, 0);

        // Just below the window aliases into RAM as a normal access.
        do_txn("bnd_wr", 1'b1, 32'h0000_3FFC, 4'hF, 32'hCAFE_F00D, 0, 0);
        do_txn("bnd_rd", 1'b0, 32'hFFFE_FFFC, 4'hF, 32'h0,         0, 3);

        // Backpressure: FIFO fills, fifth request waits for the first pop.
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0100; be_i = 4'hF;
        gnt_delay_i = 4'd0; rvalid_delay_i = 4'd15;
        grants = 0; rvs = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk_i);
            if (c == 4) begin
                chk("bp_gnt_held", {31'd0, gnt_o}, 32'd0);
                chk("bp_outst_full", {29'd0, outstanding_o}, 32'd4);
            end
            if (gnt_o && req_i) begin
                grants++;
                if (grants == 5) chk("bp_resume_cyc", c, 32'd16);
            end
            if (rvalid_o) begin
                rvs++;
                chk("bp_rdata", rdata_o, 32'hDEAD_BEEF);
                if (rvs == 1) chk("bp_first_rv_cyc", c, 32'd16);
            end
            tick();
            if (grants == 5) req_i = 1'b0;
            if (rvs == 5) break;
        end
        chk("bp_grants", grants, 32'd5);
        chk("bp_rvalids", rvs, 32'd5);

        // Reset with three responses pending.
        req_i = 1'b1; rvalid_delay_i = 4'd15;
        repeat (3) tick();
        req_i = 1'b0;
        @(negedge clk_i);
        chk("rst_pre_outst", {29'd0, outstanding_o}, 32'd3);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("rst_mid_outst", {29'd0, outstanding_o}, 32'd0);
        repeat (2) tick();
        rst_ni = 1'b1;
        rvs = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (rvalid_o) rvs++;
            tick();
        end
        chk("rst_no_rvalid", rvs, 32'd0);
        do_txn("rst_ram_kept", 1'b0, 32'h0000_0100, 4'hF, 32'h0, 0, 0);

        // Randomised traffic over a small working set.
        for (int i = 0; i < 8; i++)
            do_txn("rnd_init", 1'b1, 32'h0000_0200 + 32'(4*i), 4'hF, $urandom,
                   0, int'($urandom_range(0, 3)));
        for (int i = 0; i < 30; i++) begin
            k   = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 7));
            a   = 32'h0000_0200 + 32'(4*sel);
            case (k)
                0: do_txn("rnd_wr", 1'b1, a, 4'($urandom), $urandom,
                          int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
                1: do_txn("rnd_rd", 1'b0, a, 4'hF, 32'h0,
                          int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
                2: do_txn("rnd_err", 1'($urandom), 32'hFFFF_0000 | a, 4'hF, $urandom,
                          int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
                default: do_txn("rnd_alias", 1'b0, a | 32'h0010_0000, 4'hF, 32'h0,
                          int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
